alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Parametrised, registered successor to the combinational ALU control decoder. Accepts an ALUOp/funct pair over a valid/ready handshake and decodes it to an ALU operation code. Sequences multi-cycle operations (MUL, optional DIV/REM) by holding a busy window of configurable length. Sits between the main control unit and the ALU/multiplier datapath, and provides the stall source for the issue stage.

## Interface
- `ALUOP_W`, 4: width of `alu_op`.
- `FUNCT_W`, 4: width of `funct`, extended from 3 bits to reach the multi-cycle functs.
- `OP_W`, 4: width of `alu_operation`.
- `MUL_CYCLES`, 3: busy cycles for MUL (≥1).
- `DIV_CYCLES`, 8: busy cycles for DIV/REM (≥1).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous abort of the operation in flight.
- `in_valid` in 1: request present.
- `in_ready` out 1: request accepted when `in_valid & in_ready`.
- `alu_op` in `ALUOP_W`: opcode class.
- `funct` in `FUNCT_W`: R-type function field.
- `out_valid` out 1: decoded result present.
- `out_ready` in 1: consumer accepts the result.
- `alu_operation` out `OP_W`: decoded ALU operation.
- `multi_cycle` out 1: result came from a MUL/DIV/REM request.
- `illegal` out 1: the encoding was not recognised.
- `busy` out 1: a multi-cycle window is in progress.

## Operation
- ALUOp decode:
  - 0000 R-type: funct 0–6 → op 0–6; funct 7 → MUL (op 7); funct 8 → DIV (op 8); funct 9 → REM (op 9).
  - 0001 addi → 0; 0011 ori → 3; 0111 lw → 0; 1000 sw → 0.
  - 1001/1010/1011/1100 (beq/bne/blt/bgt) → 1 (subtract).
  - Any other ALUOp or funct → op 0 with `illegal`=1.
- FSM states IDLE, BUSY, HOLD. Reset → IDLE.
  - IDLE: `in_ready`=1. On handshake, register the decode result.
    - Single-cycle op → HOLD.
    - MUL → BUSY with counter=MUL_CYCLES−1.
    - DIV/REM → BUSY with counter=DIV_CYCLES−1.
  - BUSY: `busy`=1, `in_ready`=0. Counter decrements each cycle. At counter==0 → HOLD.
  - HOLD: `out_valid`=1; outputs stay stable until `out_ready`.
    - `in_ready` = `out_ready`, allowing back-to-back acceptance.
    - On `out_ready` with no new request → IDLE.
    - On `out_ready` with a new request accepted → behave as IDLE acceptance.
- Counter width is `$clog2(max(MUL_CYCLES,DIV_CYCLES))`, minimum 1 bit. The counter saturates at 0 and never wraps.
- `flush` → IDLE next cycle, discarding the held or busy op. `flush` has priority over any handshake in the same cycle. `rst` has priority over `flush`.
- `in_valid` while BUSY is not accepted; the requester must hold its request. Illegal encodings are single-cycle and never enter BUSY.

## Timing
- Reset values: `in_ready`=0 during reset, then 1 in the first IDLE cycle. `out_valid`, `alu_operation`, `multi_cycle`, `illegal` and `busy` all reset to 0.
- Latency, handshake to `out_valid`:
  - Single-cycle op: 1 cycle.
  - MUL: 1+MUL_CYCLES.
  - DIV/REM: 1+DIV_CYCLES.
- Throughput: one single-cycle op per clock while `out_ready`=1.
- All outputs are registered except `in_ready`, which is combinational from state and `out_ready`.

## Configuration
- `ALU_SEQ_DIV_EN` defined: DIV/REM are decoded and sequenced as above.
- Undefined: funct 8/9 decode as illegal (op 0, single-cycle). `DIV_CYCLES` is ignored and the counter is sized from `MUL_CYCLES` alone.

## Structure
- Shared package `alu_pkg`:
  - ALUOp localparams (ALUOP_RTYPE, ALUOP_ADDI, …).
  - ALU operation codes (OP_ADD=0 … OP_REM=9).
  - FSM state typedef.
- Sub-module `alu_op_decode` holds the purely combinational ALUOp/funct → {op, is_mul, is_div, illegal} map, instantiated once in front of the FSM register.

## Test plan
- Reset, then ALUOp 0001 with `out_ready`=1 → `out_valid`=1 one cycle after the handshake, `alu_operation`=0, `illegal`=0.
- Back-to-back R-type funct 2, 5, 6 with `out_ready`=1 → ops 2, 5, 6 on consecutive cycles, with `in_ready` held at 1.
- MUL (ALUOp 0000, funct 7), MUL_CYCLES=3 → `busy`=1 for 3 cycles, then `out_valid` with op 7 and `multi_cycle`=1 at cycle 4; `in_valid` during BUSY is not accepted.
- HOLD with `out_ready`=0 for 5 cycles → outputs stable; `out_ready`=1 → IDLE next cycle.
- ALUOp 1111 and funct 0xF → `illegal`=1, op 0. With `ALU_SEQ_DIV_EN` undefined, funct 8 → `illegal`=1.
- DIV in BUSY with `flush` asserted on its 2nd cycle → IDLE next cycle, no `out_valid`; `rst` asserted mid-HOLD → all outputs 0 on the next edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU control path: ALUOp classes, ALU operation codes
// and the sequencer FSM state encoding.
package alu_pkg;

  localparam logic [3:0] ALUOP_RTYPE = 4'b0000;
  localparam logic [3:0] ALUOP_ADDI  = 4'b0001;
  localparam logic [3:0] ALUOP_ORI   = 4'b0011;
  localparam logic [3:0] ALUOP_LW    = 4'b0111;
  localparam logic [3:0] ALUOP_SW    = 4'b1000;
  localparam logic [3:0] ALUOP_BEQ   = 4'b1001;
  localparam logic [3:0] ALUOP_BNE   = 4'b1010;
  localparam logic [3:0] ALUOP_BLT   = 4'b1011;
  localparam logic [3:0] ALUOP_BGT   = 4'b1100;

  // R-type functs 0..9 map one-to-one onto these codes.
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;
  localparam logic [3:0] OP_DIV = 4'd8;
  localparam logic [3:0] OP_REM = 4'd9;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_HOLD = 2'd2;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/result bundle between the control unit (master) and the
// ALU op sequencer (slave).
interface alu_op_sequencer_if #(
  parameter int ALUOP_W = 4,
  parameter int FUNCT_W = 4,
  parameter int OP_W    = 4
) ();

  logic               in_valid;
  logic               in_ready;
  logic [ALUOP_W-1:0] alu_op;
  logic [FUNCT_W-1:0] funct;
  logic               out_valid;
  logic               out_ready;
  logic [OP_W-1:0]    alu_operation;
  logic               multi_cycle;
  logic               illegal;
  logic               busy;

  modport master (
    output in_valid, alu_op, funct, out_ready,
    input  in_ready, out_valid, alu_operation, multi_cycle, illegal, busy
  );

  modport slave (
    input  in_valid, alu_op, funct, out_ready,
    output in_ready, out_valid, alu_operation, multi_cycle, illegal, busy
  );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/funct to ALU operation map. DIV/REM decode only when
// ALU_SEQ_DIV_EN is defined; otherwise funct 8/9 are illegal.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int ALUOP_W = 4,
  parameter int FUNCT_W = 4,
  parameter int OP_W    = 4
) (
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic [OP_W-1:0]    op,
  output logic               is_mul,
  output logic               is_div,
  output logic               illegal
);

  always_comb begin
    op      = OP_W'(OP_ADD);
    is_mul  = 1'b0;
    is_div  = 1'b0;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_W'(ALUOP_RTYPE): begin
        if (funct <= FUNCT_W'(OP_SLL)) begin
          op = OP_W'(funct);
        end else if (funct == FUNCT_W'(OP_MUL)) begin
          op     = OP_W'(OP_MUL);
          is_mul = 1'b1;
`ifdef ALU_SEQ_DIV_EN
        end else if (funct == FUNCT_W'(OP_DIV)) begin
          op     = OP_W'(OP_DIV);
          is_div = 1'b1;
        end else if (funct == FUNCT_W'(OP_REM)) begin
          op     = OP_W'(OP_REM);
          is_div = 1'b1;
`endif
        end else begin
          illegal = 1'b1;
        end
      end
      ALUOP_W'(ALUOP_ADDI), ALUOP_W'(ALUOP_LW), ALUOP_W'(ALUOP_SW):
        op = OP_W'(OP_ADD);
      ALUOP_W'(ALUOP_ORI):
        op = OP_W'(OP_OR);
      ALUOP_W'(ALUOP_BEQ), ALUOP_W'(ALUOP_BNE), ALUOP_W'(ALUOP_BLT), ALUOP_W'(ALUOP_BGT):
        op = OP_W'(OP_SUB);
      default:
        illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Registered ALU control decoder with a busy window for MUL (and DIV/REM when
// ALU_SEQ_DIV_EN is defined); also the issue-stage stall source via busy.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int ALUOP_W    = 4,
  parameter int FUNCT_W    = 4,
  parameter int OP_W       = 4,
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  alu_op_sequencer_if.slave  bus
);

`ifdef ALU_SEQ_DIV_EN
  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
`else
  localparam int MAX_CYC = MUL_CYCLES;
`endif
  localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [OP_W-1:0] dec_op;
  logic            dec_is_mul;
  logic            dec_is_div;
  logic            dec_illegal;
  logic            accept;
  logic [CNT_W-1:0] cnt_load;

  alu_op_decode #(
    .ALUOP_W (ALUOP_W),
    .FUNCT_W (FUNCT_W),
    .OP_W    (OP_W)
  ) u_decode (
    .alu_op  (bus.alu_op),
    .funct   (bus.funct),
    .op      (dec_op),
    .is_mul  (dec_is_mul),
    .is_div  (dec_is_div),
    .illegal (dec_illegal)
  );

  // Ready drops under reset or flush so a flushed cycle never looks accepted.
  assign bus.in_ready = !rst && !flush &&
                        ((state == ST_IDLE) || (state == ST_HOLD && bus.out_ready));
  assign accept   = bus.in_valid && bus.in_ready;
  assign cnt_load = dec_is_mul ? CNT_W'(MUL_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      cnt               <= '0;
      bus.out_valid     <= 1'b0;
      bus.alu_operation <= '0;
      bus.multi_cycle   <= 1'b0;
      bus.illegal       <= 1'b0;
      bus.busy          <= 1'b0;
    end else if (flush) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
    end else if (accept) begin
      bus.alu_operation <= dec_op;
      bus.multi_cycle   <= dec_is_mul || dec_is_div;
      bus.illegal       <= dec_illegal;
      if (dec_is_mul || dec_is_div) begin
        state         <= ST_BUSY;
        cnt           <= cnt_load;
        bus.busy      <= 1'b1;
        bus.out_valid <= 1'b0;
      end else begin
        state         <= ST_HOLD;
        bus.busy      <= 1'b0;
        bus.out_valid <= 1'b1;
      end
    end else if (state == ST_HOLD) begin
      if (bus.out_ready) begin
        state         <= ST_IDLE;
        bus.out_valid <= 1'b0;
      end
    end else if (state == ST_BUSY) begin
      // Counter only moves while non-zero, so it can never wrap.
      if (cnt == '0) begin
        state         <= ST_HOLD;
        bus.busy      <= 1'b0;
        bus.out_valid <= 1'b1;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end else if (state != ST_IDLE) begin
      state         <= ST_IDLE;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer (default MUL_CYCLES=3,
// DIV_CYCLES=8); DIV/REM steps run only when ALU_SEQ_DIV_EN is defined.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic clk;
  logic rst;
  logic flush;
  int   n_cmp;
  int   n_err;

  alu_op_sequencer_if #(.ALUOP_W(4), .FUNCT_W(4), .OP_W(4)) bus ();

  alu_op_sequencer #(
    .ALUOP_W    (4),
    .FUNCT_W    (4),
    .OP_W       (4),
    .MUL_CYCLES (3),
    .DIV_CYCLES (8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [3:0] op,
                           input logic mc, input logic ill, input logic bsy);
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(v));
    check({tag, ".op"},        32'(bus.alu_operation), 32'(op));
    check({tag, ".multi"},     32'(bus.multi_cycle), 32'(mc));
    check({tag, ".illegal"},   32'(bus.illegal), 32'(ill));
    check({tag, ".busy"},      32'(bus.busy), 32'(bsy));
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.alu_op    = 4'd0;
    bus.funct     = 4'd0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst.in_ready", 32'(bus.in_ready), 32'd0);
    check_out("rst", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check("idle.in_ready", 32'(bus.in_ready), 32'd1);

    // addi, single-cycle
    bus.in_valid  = 1'b1;
    bus.alu_op    = 4'b0001;
    bus.out_ready = 1'b1;
    tick();
    check_out("addi", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    tick();
    check("addi.drain", 32'(bus.out_valid), 32'd0);

    // back-to-back R-type 2, 5, 6
    bus.in_valid = 1'b1;
    bus.alu_op   = 4'b0000;
    bus.funct    = 4'd2;
    #1;
    check("b2b.ready0", 32'(bus.in_ready), 32'd1);
    tick();
    check_out("b2b.f2", 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    bus.funct = 4'd5;
    #1;
    check("b2b.ready1", 32'(bus.in_ready), 32'd1);
    tick();
    check_out("b2b.f5", 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    bus.funct = 4'd6;
    #1;
    check("b2b.ready2", 32'(bus.in_ready), 32'd1);
    tick();
    check_out("b2b.f6", 1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    tick();
    check("b2b.drain", 32'(bus.out_valid), 32'd0);

    // MUL: busy 3 cycles, result on the 4th edge; a different request is refused meanwhile
    bus.in_valid = 1'b1;
    bus.funct    = 4'd7;
    tick();
    check_out("mul.b1", 1'b0, 4'd7, 1'b1, 1'b0, 1'b1);
    bus.funct     = 4'd2;
    bus.out_ready = 1'b0;
    #1;
    check("mul.in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    check("mul.b2", 32'(bus.busy), 32'd1);
    tick();
    check("mul.b3", 32'(bus.busy), 32'd1);
    tick();
    check_out("mul.done", 1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold.valid", 32'(bus.out_valid), 32'd1);
      check("hold.op", 32'(bus.alu_operation), 32'd7);
    end
    bus.out_ready = 1'b1;
    tick();
    check("hold.release", 32'(bus.out_valid), 32'd0);
    check("hold.idle_ready", 32'(bus.in_ready), 32'd1);

    // illegal encodings and branch decode, back-to-back
    bus.in_valid = 1'b1;
    bus.alu_op   = 4'b1111;
    bus.funct    = 4'd0;
    tick();
    check_out("ill.aluop", 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
    bus.alu_op = 4'b0000;
    bus.funct  = 4'hF;
    tick();
    check_out("ill.funct", 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
    bus.alu_op = 4'b1010;
    bus.funct  = 4'hF;
    tick();
    check_out("bne", 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
`ifndef ALU_SEQ_DIV_EN
    bus.alu_op = 4'b0000;
    bus.funct  = 4'd8;
    tick();
    check_out("ill.div", 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
`endif
    bus.in_valid = 1'b0;
    tick();
    check("ill.drain", 32'(bus.out_valid), 32'd0);

`ifdef ALU_SEQ_DIV_EN
    // REM full latency 1+DIV_CYCLES
    bus.in_valid = 1'b1;
    bus.alu_op   = 4'b0000;
    bus.funct    = 4'd9;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("rem.busy", 32'(bus.busy), 32'd1);
    end
    tick();
    check_out("rem.done", 1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
    tick();
`endif

    // flush on the 2nd busy cycle
    bus.in_valid = 1'b1;
    bus.alu_op   = 4'b0000;
`ifdef ALU_SEQ_DIV_EN
    bus.funct    = 4'd8;
`else
    bus.funct    = 4'd7;
`endif
    tick();
    check("flush.b1", 32'(bus.busy), 32'd1);
    bus.in_valid = 1'b0;
    tick();
    check("flush.b2", 32'(bus.busy), 32'd1);
    flush = 1'b1;
    #1;
    check("flush.in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    flush = 1'b0;
    check("flush.busy", 32'(bus.busy), 32'd0);
    check("flush.valid", 32'(bus.out_valid), 32'd0);
    #1;
    check("flush.idle_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("flush.quiet", 32'(bus.out_valid), 32'd0);
    end

    // reset in the middle of HOLD
    bus.in_valid  = 1'b1;
    bus.alu_op    = 4'b0011;
    bus.out_ready = 1'b0;
    tick();
    check_out("ori", 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    check_out("rst.hold", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    check("rst.hold.in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
